aes_128_keyram_writer: RTL and testbench

Write-side controller for the double-buffered AES-128 round-key RAM. It accepts a 128-bit cipher key, expands it into the 11 round keys (22 64-bit words) using the shared BRAM s-box, and writes them into one of two 22-word banks. Bank base addresses are 0 and LENGTH_KEY_SET. It then hands the filled bank to the key-RAM read controller. Bank ownership is tracked with full flags, so a bank is never overwritten while the reader is still consuming it.

---
 rtl/aes_128_keyram_writer.sv | 144 ++++++++++++++
 tb/tb_aes_128_keyram_writer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_128_keyram_writer.sv
// AES-128 key-expansion writer for the double-buffered round-key RAM (two banks of 22 x 64-bit words).
// Optional macro KEYRAM_WR_REVERSE_EN stores rounds in decryption order (round 10 at the bank base).
module aes_128_keyram_writer #(
  parameter int LENGTH_KEY_SET = 22,
  parameter int ADDR_W         = 6
) (
  input  logic              clk,
  input  logic              kill_n,
  input  logic [127:0]      key_in,
  input  logic              key_valid,
  output logic              key_accept,
  output logic [31:0]       sbox_addr,
  input  logic [31:0]       sbox_data,
  output logic [63:0]       ram_din,
  output logic [ADDR_W-1:0] ram_addr_wr,
  output logic              ram_we,
  output logic              bank_ready,
  output logic              bank_ready_idx,
  input  logic              bank_release,
  input  logic              release_idx
);

  typedef enum logic [2:0] {IDLE, W0LO, W0HI, SBOX, WLO, WHI, DONE} state_t;

  state_t        state, state_nxt;
  logic [127:0]  key_r;
  logic [7:0]    rcon;
  logic [3:0]    round;
  logic [1:0]    full, full_nxt;
  logic          wr_bank;

  logic [31:0]   tw, nw0, nw1, nw2, nw3;
  logic [127:0]  key_nxt;
  logic [3:0]    slot;
  logic [ADDR_W-1:0] base, addr_lo;

  assign key_accept = (state == IDLE) & ~full[wr_bank];

  // FIPS-197 expansion step; sbox_data already holds SubWord(RotWord(w3)).
  assign tw      = sbox_data ^ {rcon, 24'h0};
  assign nw0     = key_r[127:96] ^ tw;
  assign nw1     = key_r[95:64]  ^ nw0;
  assign nw2     = key_r[63:32]  ^ nw1;
  assign nw3     = key_r[31:0]   ^ nw2;
  assign key_nxt = {nw0, nw1, nw2, nw3};

`ifdef KEYRAM_WR_REVERSE_EN
  assign slot = 4'd10 - round;
`else
  assign slot = round;
`endif
  assign base    = wr_bank ? ADDR_W'(LENGTH_KEY_SET) : '0;
  assign addr_lo = base + ADDR_W'({slot, 1'b0});

  always_comb begin
    state_nxt   = state;
    ram_we      = 1'b0;
    ram_din     = '0;
    ram_addr_wr = '0;
    bank_ready  = 1'b0;
    case (state)
      IDLE: if (key_valid && key_accept) state_nxt = W0LO;
      W0LO: begin
        ram_we      = 1'b1;
        ram_din     = key_r[63:0];
        ram_addr_wr = addr_lo;
        state_nxt   = W0HI;
      end
      W0HI: begin
        ram_we      = 1'b1;
        ram_din     = key_r[127:64];
        ram_addr_wr = addr_lo + ADDR_W'(1);
        state_nxt   = SBOX;
      end
      SBOX: state_nxt = WLO;
      WLO: begin
        ram_we      = 1'b1;
        ram_din     = key_nxt[63:0];
        ram_addr_wr = addr_lo;
        state_nxt   = WHI;
      end
      WHI: begin
        ram_we      = 1'b1;
        ram_din     = key_r[127:64];
        ram_addr_wr = addr_lo + ADDR_W'(1);
        state_nxt   = (round == 4'd10) ? DONE : SBOX;
      end
      DONE: begin
        bank_ready = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The set of a finishing bank wins over a release of that same bank.
  always_comb begin
    full_nxt = full;
    if (bank_release && !(state != IDLE && release_idx == wr_bank))
      full_nxt[release_idx] = 1'b0;
    if (state == DONE)
      full_nxt[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      state          <= IDLE;
      key_r          <= '0;
      rcon           <= 8'h01;
      round          <= '0;
      full           <= '0;
      wr_bank        <= 1'b0;
      sbox_addr      <= '0;
      bank_ready_idx <= 1'b0;
    end else begin
      state <= state_nxt;
      full  <= full_nxt;
      case (state)
        IDLE: if (key_valid && key_accept) begin
          key_r <= key_in;
          rcon  <= 8'h01;
          round <= '0;
        end
        W0HI: begin
          round     <= round + 4'd1;
          sbox_addr <= {key_r[23:0], key_r[31:24]};
        end
        WLO: key_r <= key_nxt;
        WHI: begin
          rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
          if (round == 4'd10) begin
            bank_ready_idx <= wr_bank;  // valid during the bank_ready pulse
          end else begin
            round     <= round + 4'd1;
            sbox_addr <= {key_r[23:0], key_r[31:24]};
          end
        end
        DONE: wr_bank <= ~wr_bank;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_128_keyram_writer.sv
// Scoreboard bench: FIPS-197 reference expansion feeds expected RAM writes; a monitor pops and compares.
module tb_aes_128_keyram_writer;
  localparam int LKS = 22;
  localparam int AW  = 6;
`ifdef KEYRAM_WR_REVERSE_EN
  localparam bit REV = 1'b1;
`else
  localparam bit REV = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          kill_n = 1'b0;
  logic [127:0]  key_in = '0;
  logic          key_valid = 1'b0;
  logic          key_accept;
  logic [31:0]   sbox_addr;
  logic [31:0]   sbox_data = '0;
  logic [63:0]   ram_din;
  logic [AW-1:0] ram_addr_wr;
  logic          ram_we;
  logic          bank_ready;
  logic          bank_ready_idx;
  logic          bank_release = 1'b0;
  logic          release_idx = 1'b0;

  aes_128_keyram_writer #(.LENGTH_KEY_SET(LKS), .ADDR_W(AW)) dut (
    .clk(clk), .kill_n(kill_n), .key_in(key_in), .key_valid(key_valid),
    .key_accept(key_accept), .sbox_addr(sbox_addr), .sbox_data(sbox_data),
    .ram_din(ram_din), .ram_addr_wr(ram_addr_wr), .ram_we(ram_we),
    .bank_ready(bank_ready), .bank_ready_idx(bank_ready_idx),
    .bank_release(bank_release), .release_idx(release_idx));

  always #5 clk = ~clk;

  logic [7:0] sbox [256];
  always @(posedge clk)
    sbox_data <= {sbox[sbox_addr[31:24]], sbox[sbox_addr[23:16]],
                  sbox[sbox_addr[15:8]], sbox[sbox_addr[7:0]]};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [AW-1:0] addr; logic [63:0] data; } wr_t;
  wr_t  exp_wr[$];
  bit   exp_idx[$];
  int   n_cmp = 0, n_bad = 0;
  bit   model_full[2];
  bit   model_wr = 1'b0;
  bit   busy = 1'b0;
  bit   fill_bank = 1'b0;
  int   hs_cyc = 0;
  logic [63:0] tb_ram [64];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, x = a, y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic push_key(input logic [127:0] k, input bit bank);
    logic [31:0] w [44];
    logic [31:0] t;
    int rc = 1;
    wr_t e;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t = t ^ {rc[7:0], 24'h0};
        rc = rc << 1;
        if (rc > 255) rc = rc ^ 'h11b;
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) begin
      int a = int'(bank) * LKS + 2 * (REV ? 10 - r : r);
      e.addr = AW'(a);     e.data = {w[4*r+2], w[4*r+3]}; exp_wr.push_back(e);
      e.addr = AW'(a + 1); e.data = {w[4*r],   w[4*r+1]}; exp_wr.push_back(e);
    end
    exp_idx.push_back(bank);
  endtask

  task automatic model_release(input bit idx);
    if (!(busy && idx == fill_bank)) model_full[idx] = 1'b0;
  endtask

  // Called at a negedge; returns just after the handshake edge.
  task automatic send_key(input logic [127:0] k);
    int n = 0;
    @(negedge clk);
    key_in = k; key_valid = 1'b1;
    while (!key_accept && n < 200) begin @(negedge clk); n++; end
    if (!key_accept) begin
      n_cmp++; n_bad++;
      $display("FAIL send_key_timeout: key_accept 0 after 200 cycles, required 1");
      key_valid = 1'b0;
      return;
    end
    hs_cyc = cyc + 1;
    fill_bank = model_wr; busy = 1'b1;
    model_full[model_wr] = 1'b1;
    push_key(k, model_wr);
    model_wr = !model_wr;
    @(posedge clk); #1 key_valid = 1'b0;
  endtask

  // Caller is at a negedge; pulse lasts one cycle, returns at the next negedge.
  task automatic rel_now(input bit idx);
    bank_release = 1'b1; release_idx = idx;
    model_release(idx);
    @(negedge clk);
    bank_release = 1'b0;
  endtask

  task automatic wait_set();
    repeat (34) @(negedge clk);
    busy = 1'b0;
  endtask

  task automatic chk_accept(input string name);
    chk(name, 128'(key_accept), 128'(!model_full[model_wr]));
  endtask

  task automatic monitor();
    wr_t e;
    bit  bi;
    forever begin
      @(negedge clk);
      if (kill_n) begin
        if (ram_we) begin
          tb_ram[ram_addr_wr] = ram_din;
          if (exp_wr.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_write: addr %0d data %h, required no write", ram_addr_wr, ram_din);
          end else begin
            e = exp_wr.pop_front();
            chk("wr_addr", 128'(ram_addr_wr), 128'(e.addr));
            chk("wr_data", 128'(ram_din), 128'(e.data));
          end
        end
        if (bank_ready) begin
          if (exp_idx.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL spurious_bank_ready: idx %0d, required no pulse", bank_ready_idx);
          end else begin
            bi = exp_idx.pop_front();
            chk("bank_ready_idx", 128'(bank_ready_idx), 128'(bi));
            chk("bank_ready_cycle", 128'(cyc - hs_cyc + 1), 128'(33));
          end
        end
      end
    end
  endtask

  initial begin
    logic [127:0] k;
    build_sbox();
    model_full[0] = 1'b0; model_full[1] = 1'b0;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    kill_n = 1'b1;
    @(negedge clk);
    chk("rst_key_accept", 128'(key_accept), 128'(1));
    chk("rst_ram_we", 128'(ram_we), 128'(0));
    chk("rst_bank_ready", 128'(bank_ready), 128'(0));
    chk("rst_bank_ready_idx", 128'(bank_ready_idx), 128'(0));
    chk("rst_sbox_addr", 128'(sbox_addr), 128'(0));
    chk("rst_ram_addr_wr", 128'(ram_addr_wr), 128'(0));
    chk("rst_ram_din", 128'(ram_din), 128'(0));

    // FIPS-197 key into bank 0
    send_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    wait_set();
`ifdef KEYRAM_WR_REVERSE_EN
    chk("fips_ram0",  128'(tb_ram[0]),  128'(64'he13f0cc8b6630ca6));
    chk("fips_ram1",  128'(tb_ram[1]),  128'(64'hd014f9a8c9ee2589));
    chk("fips_ram20", 128'(tb_ram[20]), 128'(64'habf7158809cf4f3c));
    chk("fips_ram21", 128'(tb_ram[21]), 128'(64'h2b7e151628aed2a6));
`else
    chk("fips_ram0",  128'(tb_ram[0]),  128'(64'habf7158809cf4f3c));
    chk("fips_ram1",  128'(tb_ram[1]),  128'(64'h2b7e151628aed2a6));
    chk("fips_ram2",  128'(tb_ram[2]),  128'(64'h23a339392a6c7605));
    chk("fips_ram3",  128'(tb_ram[3]),  128'(64'ha0fafe1788542cb1));
    chk("fips_ram21", 128'(tb_ram[21]), 128'(64'hd014f9a8c9ee2589));
`endif
    chk_accept("accept_after_set0");

    // Second key to bank 1; then both full, third held off until bank 0 is released
    send_key({$urandom, $urandom, $urandom, $urandom});
    wait_set();
    chk_accept("accept_both_full");
    k = {$urandom, $urandom, $urandom, $urandom};
    key_in = k; key_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_accept("holdoff_accept");
    end
    key_valid = 1'b0;
    rel_now(1'b0);
    chk_accept("accept_after_release0");
    send_key(k);
    wait_set();

    // Release bank 1, refill it, and release bank 0 in the DONE cycle
    rel_now(1'b1);
    send_key({$urandom, $urandom, $urandom, $urandom});
    repeat (33) @(negedge clk);
    rel_now(1'b0);
    busy = 1'b0;
    chk_accept("accept_release_at_done_other");

    // Release of the bank being completed in its own DONE cycle is ignored
    send_key({$urandom, $urandom, $urandom, $urandom});
    repeat (33) @(negedge clk);
    rel_now(1'b0);
    busy = 1'b0;
    chk_accept("accept_release_at_done_same");
    rel_now(1'b1);
    chk_accept("accept_after_release1");
    rel_now(1'b1);
    chk_accept("accept_release_empty");

    // Kill in the middle of a set (round 5 low-word write)
    send_key({$urandom, $urandom, $urandom, $urandom});
    repeat (16) @(negedge clk);
    #2 kill_n = 1'b0;
    #1;
    exp_wr.delete(); exp_idx.delete();
    model_full[0] = 1'b0; model_full[1] = 1'b0; model_wr = 1'b0; busy = 1'b0;
    chk("kill_ram_we", 128'(ram_we), 128'(0));
    chk("kill_bank_ready", 128'(bank_ready), 128'(0));
    chk_accept("kill_accept");
    @(negedge clk);
    kill_n = 1'b1;
    send_key({$urandom, $urandom, $urandom, $urandom});
    wait_set();

    // Random traffic with random releases
    for (int i = 0; i < 4; i++) begin
      if (model_full[model_wr] || ($urandom % 2 == 0)) rel_now(model_wr);
      send_key({$urandom, $urandom, $urandom, $urandom});
      wait_set();
      chk_accept("accept_random");
    end

    repeat (4) @(negedge clk);
    chk("exp_wr_drained", 128'(exp_wr.size()), 128'(0));
    chk("exp_idx_drained", 128'(exp_idx.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
